// File: rtl/reg_desloc.sv
// reg_desloc: WIDTH-bit universal shift register (hold, shift right, shift left,
// parallel load) selected by a 2-bit opcode; output driven straight from the flops.
module reg_desloc #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] out
);

  localparam logic [1:0] OP_HOLD  = 2'b00;
  localparam logic [1:0] OP_SHR   = 2'b01;
  localparam logic [1:0] OP_SHL   = 2'b10;
  localparam logic [1:0] OP_LOAD  = 2'b11;

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next-state decode; anything unrecognised holds the current contents.
  always_comb begin
    q_d = q_q;
    unique case (op)
      OP_HOLD: q_d = q_q;
      OP_SHR:  q_d = {serial_in, q_q[WIDTH-1:1]};
      OP_SHL:  q_d = {q_q[WIDTH-2:0], serial_in};
      OP_LOAD: q_d = parallel_in;
      default: q_d = q_q;
    endcase
  end

  // Register stage; synchronous reset overrides every opcode.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign out = q_q;

endmodule

// File: tb/tb_reg_desloc.sv
// tb_reg_desloc: scoreboard bench for reg_desloc with directed test-plan
// sequences followed by a randomised stream.
module tb_reg_desloc;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         serial_in;
  logic [W-1:0] parallel_in;
  logic [1:0]   op;
  logic [W-1:0] out;

  logic [W-1:0] model_q;
  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;

  always #5 clk = ~clk;

  reg_desloc #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .serial_in   (serial_in),
    .parallel_in (parallel_in),
    .op          (op),
    .out         (out)
  );

  task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, obs, expv);
    end
  endtask

  // Drive one edge's worth of stimulus, predict the result, compare after the edge.
  task automatic step(input string tag, input logic r, input logic [1:0] o,
                      input logic s, input logic [W-1:0] p);
    logic [W-1:0] e;
    @(negedge clk);
    reset = r; op = o; serial_in = s; parallel_in = p;
    if (r) model_q = '0;
    else begin
      case (o)
        2'b01:   model_q = {s, model_q[W-1:1]};
        2'b10:   model_q = {model_q[W-2:0], s};
        2'b11:   model_q = p;
        default: model_q = model_q;
      endcase
    end
    exp_q.push_back(model_q);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_val({tag, "_sb_empty"}, out, ~out);
    end else begin
      e = exp_q.pop_front();
      check_val({tag, "_sb"}, out, e);
    end
  endtask

  // Step plus a check against a hard-coded test-plan value.
  task automatic step_c(input string tag, input logic r, input logic [1:0] o,
                        input logic s, input logic [W-1:0] p, input logic [W-1:0] want);
    step(tag, r, o, s, p);
    check_val(tag, out, want);
  endtask

  initial begin
    reset = 1'b1; op = 2'b00; serial_in = 1'b0; parallel_in = '0;
    model_q = 'x;

    // Reset and hold
    step_c("rst0", 1'b1, 2'b00, 1'b0, 4'b0000, 4'b0000);
    step_c("ld_pre", 1'b0, 2'b11, 1'b0, 4'b0110, 4'b0110);
    step_c("rst_prio", 1'b1, 2'b11, 1'b1, 4'b1111, 4'b0000);
    for (int i = 0; i < 3; i++) step_c("rst_hold", 1'b0, 2'b00, 1'b1, 4'b1111, 4'b0000);

    // Parallel load and hold
    step_c("ld_1010", 1'b0, 2'b11, 1'b0, 4'b1010, 4'b1010);
    for (int i = 0; i < 4; i++) step_c("hold", 1'b0, 2'b00, 1'(i), 4'b0101, 4'b1010);

    // Reset glitch between edges must not clear
    #2 reset = 1'b1;
    #1 reset = 1'b0;
    step_c("glitch", 1'b0, 2'b00, 1'b0, 4'b0000, 4'b1010);

    // Shift right
    step_c("ld_0000", 1'b0, 2'b11, 1'b0, 4'b0000, 4'b0000);
    step_c("shr1", 1'b0, 2'b01, 1'b1, 4'b0000, 4'b1000);
    step_c("shr2", 1'b0, 2'b01, 1'b1, 4'b0000, 4'b1100);
    step_c("shr3", 1'b0, 2'b01, 1'b1, 4'b0000, 4'b1110);
    step_c("shr4", 1'b0, 2'b01, 1'b1, 4'b0000, 4'b1111);
    step_c("shr5", 1'b0, 2'b01, 1'b0, 4'b0000, 4'b0111);
    step_c("shr6", 1'b0, 2'b01, 1'b0, 4'b0000, 4'b0011);

    // Shift left
    step_c("ld_1010b", 1'b0, 2'b11, 1'b0, 4'b1010, 4'b1010);
    step_c("shl1", 1'b0, 2'b10, 1'b1, 4'b0000, 4'b0101);
    step_c("shl2", 1'b0, 2'b10, 1'b1, 4'b0000, 4'b1011);
    step_c("shl3", 1'b0, 2'b10, 1'b1, 4'b0000, 4'b0111);
    step_c("shl4", 1'b0, 2'b10, 1'b1, 4'b0000, 4'b1111);
    step_c("shl5", 1'b0, 2'b10, 1'b0, 4'b0000, 4'b1110);

    // Mixed sequence
    step("mix_hold", 1'b0, 2'b00, 1'b0, 4'b0000);
    for (int i = 0; i < 4; i++) step("mix_shr", 1'b0, 2'b01, 1'b1, 4'b0000);
    check_val("mix_shr_all1", out, 4'b1111);
    for (int i = 0; i < 4; i++) step("mix_shl", 1'b0, 2'b10, 1'b0, 4'b0000);
    check_val("mix_shl_all0", out, 4'b0000);
    step_c("mix_ld", 1'b0, 2'b11, 1'b0, 4'b1111, 4'b1111);
    step_c("mix_rst", 1'b1, 2'b01, 1'b1, 4'b1111, 4'b0000);

    // Reset mid-shift
    step_c("ms1", 1'b0, 2'b01, 1'b1, 4'b0000, 4'b1000);
    step_c("ms2", 1'b0, 2'b01, 1'b1, 4'b0000, 4'b1100);
    step_c("ms_rst", 1'b1, 2'b01, 1'b1, 4'b0000, 4'b0000);
    step_c("ms_resume", 1'b0, 2'b01, 1'b1, 4'b0000, 4'b1000);

    // Random stream
    for (int i = 0; i < 300; i++) begin
      step("rnd", ($urandom_range(0, 19) == 0), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end

    if (exp_q.size() != 0) check_val("sb_leftover", 4'(exp_q.size()), 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
